// File: rtl/dual_fetch_ctrl.sv
// dual_fetch_ctrl: dual-issue fetch sequencer owning the PC; drives the ROM address and hands tagged pairs to decode over valid/ready (ports: clk, rst_n, fetch_en, rom_addr/rom_instr1/rom_instr2, out_valid/out_valid2/out_pc/out_instr1/out_instr2/out_ready/out_single, redirect_valid/redirect_pc, stall_cnt, redirect_cnt)
module dual_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 1024,
  parameter int          AW        = 10,
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_instr1,
  input  logic [31:0]   rom_instr2,
  output logic          out_valid,
  output logic          out_valid2,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr1,
  output logic [31:0]   out_instr2,
  input  logic          out_ready,
  input  logic          out_single,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   redirect_cnt
);
  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [AW+1:0] inc_lo;
  logic last, take;
  assign last = pc_q[AW+1:2] == AW'(ROM_WORDS - 1);
  assign out_valid = (state_q == HOLD) && !redirect_valid;
  assign out_valid2 = out_valid && !last;
  assign out_pc = pc_q;
  assign out_instr1 = out_valid ? rom_instr1 : NOP;
  assign out_instr2 = out_valid2 ? rom_instr2 : NOP;
  assign take = out_valid && out_ready;
  assign inc_lo = pc_q[AW+1:0] + ((out_single || last) ? (AW+2)'(4) : (AW+2)'(8));
  // The ROM always reads the word of the PC that will be held next cycle, so a
  // stall simply replays the same address and the pair stays stable.
  assign rom_addr = pc_d[AW+1:2];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
      state_d = HOLD;
    end else if (take) begin
      pc_d = 32'(inc_lo);
      state_d = fetch_en ? HOLD : EMPTY;
    end else if (state_q == EMPTY) begin
      state_d = fetch_en ? HOLD : EMPTY;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pc_q <= RESET_PC & ~32'h3;
      stall_cnt <= '0;
      redirect_cnt <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (redirect_valid && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dual_fetch_ctrl.sv
// tb_dual_fetch_ctrl: directed scenarios plus randomized traffic checked against a behavioural fetch model
module tb_dual_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0;
  logic fetch_en = 0, out_ready = 0, out_single = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic [9:0] rom_addr;
  logic [31:0] rom_instr1, rom_instr2, out_pc, out_instr1, out_instr2;
  logic out_valid, out_valid2;
  logic [15:0] stall_cnt, redirect_cnt;
  logic [31:0] rom [1024];
  int n_chk = 0, n_err = 0;
  logic m_v;
  logic [31:0] m_pc;
  int m_scnt, m_rcnt;

  dual_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
    .rom_instr1(rom_instr1), .rom_instr2(rom_instr2), .out_valid(out_valid),
    .out_valid2(out_valid2), .out_pc(out_pc), .out_instr1(out_instr1),
    .out_instr2(out_instr2), .out_ready(out_ready), .out_single(out_single),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    rom_instr1 <= rom[rom_addr];
    rom_instr2 <= rom[rom_addr + 10'd1];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] nxt_pc();
    int w;
    w = int'(m_pc[11:2]);
    if (redirect_valid) return redirect_pc & ~32'h3;
    if (m_v && out_ready) return (m_pc + ((out_single || w == 1023) ? 32'd4 : 32'd8)) & 32'hFFF;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_v = 0;
    m_pc = 0;
    m_scnt = 0;
    m_rcnt = 0;
  endtask

  task automatic drv(input logic fe, input logic rdy, input logic sgl, input logic rv, input logic [31:0] rpc);
    logic [31:0] np;
    int w;
    logic ov, ov2;
    fetch_en = fe;
    out_ready = rdy;
    out_single = sgl;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    w = int'(m_pc[11:2]);
    ov = m_v && !rv;
    ov2 = ov && w != 1023;
    np = nxt_pc();
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("out_valid2", 32'(out_valid2), 32'(ov2));
    chk("out_pc", out_pc, m_pc);
    chk("instr1", out_instr1, ov ? rom[w] : NOP);
    chk("instr2", out_instr2, ov2 ? rom[(w + 1) % 1024] : NOP);
    chk("rom_addr", 32'(rom_addr), 32'(np[11:2]));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("redirect_cnt", 32'(redirect_cnt), 32'(m_rcnt));
  endtask

  task automatic step();
    logic ov;
    logic [31:0] np;
    ov = m_v && !redirect_valid;
    np = nxt_pc();
    @(posedge clk);
    if (redirect_valid) begin
      m_v = 1;
      if (m_rcnt < 65535) m_rcnt++;
    end else if (ov && out_ready) m_v = fetch_en;
    else if (ov) begin
      if (m_scnt < 65535) m_scnt++;
    end else m_v = fetch_en;
    m_pc = np;
    @(negedge clk);
  endtask

  task automatic cyc(input logic fe, input logic rdy, input logic sgl, input logic rv, input logic [31:0] rpc);
    drv(fe, rdy, sgl, rv, rpc);
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    model_reset();
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr1", out_instr1, NOP);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    cyc(1, 1, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_i0", out_instr1, rom[0]);
    step();
    drv(1, 1, 0, 0, 0);
    chk("t1_pc8", out_pc, 32'h8);
    chk("t1_i3", out_instr2, rom[3]);
    step();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    chk("t2_pc", out_pc, 32'h10);
    chk("t2_stall", 32'(stall_cnt), 32'd3);
    step();
    drv(1, 1, 0, 0, 0);
    chk("t2_resume", out_pc, 32'h18);
    step();
    cyc(1, 1, 1, 0, 0);
    drv(1, 0, 0, 0, 0);
    chk("t3_pc", out_pc, 32'h24);
    chk("t3_i1", out_instr1, rom[9]);
    chk("t3_i2", out_instr2, rom[10]);
    step();
    drv(1, 0, 0, 1, 32'h103);
    chk("t4_valid", 32'(out_valid), 32'd0);
    step();
    drv(1, 1, 0, 0, 0);
    chk("t4_pc", out_pc, 32'h100);
    chk("t4_rcnt", 32'(redirect_cnt), 32'd1);
    step();
    cyc(1, 1, 0, 1, 32'hFFC);
    drv(1, 1, 0, 0, 0);
    chk("t5_v2", 32'(out_valid2), 32'd0);
    chk("t5_i2", out_instr2, NOP);
    step();
    drv(1, 1, 0, 0, 0);
    chk("t5_wrap", out_pc, 32'h0);
    step();
    cyc(1, 1, 0, 1, 32'h40);
    cyc(0, 1, 0, 0, 0);
    drv(1, 1, 0, 0, 0);
    chk("t6_idle", 32'(out_valid), 32'd0);
    chk("t6_pc", out_pc, 32'h48);
    step();
    drv(1, 1, 0, 0, 0);
    chk("t6_resume", out_pc, 32'h48);
    step();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      int k;
      k = $urandom_range(0, 3);
      rpc = k == 0 ? 32'hFF8 + $urandom_range(0, 7) : k == 1 ? $urandom : $urandom_range(0, 4095);
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, rpc);
      if (i == 1500) begin
        rst_n = 0;
        #1;
        model_reset();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pc", out_pc, 32'd0);
        chk("mid_rst_scnt", 32'(stall_cnt), 32'd0);
        chk("mid_rst_rcnt", 32'(redirect_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1;
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
